// File: rtl/syn_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one syn_fifo write port among N_REQ requesters.
// Grants one requester per burst; beats pass straight through to the FIFO.
module syn_fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_WIDTH-1:0]       fifo_wdata,
    output logic [$clog2(N_REQ)-1:0]    grant_id,
    output logic                        grant_active
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_n;
    logic [IW-1:0] grant_n, rr_ptr, ptr_n, pick, grant_nxt;
    logic [CW-1:0] beat_cnt, cnt_n;
    logic          accept;
    logic          burst_end;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            beat_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_n;
            grant_id <= grant_n;
            beat_cnt <= cnt_n;
            rr_ptr   <= ptr_n;
        end
    end

    // First valid requester at or after rr_ptr; descending loop leaves the nearest.
    always_comb begin
        logic [IW:0] sum;
        pick = '0;
        sum  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (int'(sum) >= N_REQ)
                sum = sum - (IW + 1)'(N_REQ);
            if (req_valid[sum[IW-1:0]])
                pick = sum[IW-1:0];
        end
    end

    assign grant_nxt = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
    assign accept    = (state == BURST) & req_valid[grant_id] & ~fifo_full;
    assign burst_end = (accept & req_last[grant_id])
                     | (accept & (beat_cnt == CW'(MAX_BURST - 1)))
                     | ~req_valid[grant_id];

    always_comb begin
        state_n = state;
        grant_n = grant_id;
        cnt_n   = beat_cnt;
        ptr_n   = rr_ptr;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_n = BURST;
                    grant_n = pick;
                    cnt_n   = '0;
                end
            end
            BURST: begin
                if (accept)
                    cnt_n = beat_cnt + 1'b1;
                if (burst_end) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    ptr_n   = grant_nxt;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        if (state == BURST) begin
            req_ready[grant_id] = ~fifo_full;
            if (accept) begin
                fifo_wr    = 1'b1;
                fifo_wdata = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign grant_active = (state == BURST);

endmodule

// File: tb/tb_syn_fifo_wr_arbiter.sv
// Bench for syn_fifo_wr_arbiter: directed scenarios plus a randomized run
// checked cycle by cycle against a transaction-level arbitration model.
module tb_syn_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int FD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic          fifo_full = 1'b0;
    logic          fifo_wr;
    logic [W-1:0]  fifo_wdata;
    logic [1:0]    grant_id;
    logic          grant_active;

    int total = 0;
    int bad = 0;

    bit m_busy;
    int m_owner;
    int m_cnt;
    int m_ptr;
    bit prev_active;
    int wlog[$];
    int glog[$];
    int occ;
    bit w;

    syn_fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_wr(fifo_wr),
        .fifo_wdata(fifo_wdata),
        .grant_id(grant_id),
        .grant_active(grant_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_owner = 0;
        m_cnt = 0;
        m_ptr = 0;
        prev_active = 0;
        wlog.delete();
        glog.delete();
    endtask

    // Reset asserted between edges with inputs held: outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_active", grant_active, 0);
        chk("rst_wr", fifo_wr, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_gid", grant_id, 0);
        model_reset();
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic [N-1:0] l, input logic f, output bit wrote);
        logic [N-1:0] er;
        logic         ew;
        logic [W-1:0] ed;
        bit           found;
        @(negedge clk);
        req_valid = v;
        req_data = d;
        req_last = l;
        fifo_full = f;
        #1;
        er = (m_busy && !f) ? N'(1 << m_owner) : '0;
        ew = m_busy && v[m_owner] && !f;
        ed = ew ? d[m_owner*W +: W] : '0;
        chk("grant_active", grant_active, m_busy);
        chk("grant_id", grant_id, m_owner);
        chk("req_ready", req_ready, er);
        chk("fifo_wr", fifo_wr, ew);
        chk("fifo_wdata", fifo_wdata, ed);
        chk("wr_while_full", fifo_wr & fifo_full, 0);
        chk("ready_onehot", $onehot0(req_ready), 1);
        if (grant_active && !prev_active)
            glog.push_back(int'(grant_id));
        prev_active = grant_active;
        if (fifo_wr)
            wlog.push_back(int'(fifo_wdata));
        wrote = ew;
        @(posedge clk);
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && v[(m_ptr + k) % N]) begin
                    found = 1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            if (found) begin
                m_busy = 1;
                m_cnt = 0;
            end
        end else begin
            if (ew)
                m_cnt++;
            if ((ew && (l[m_owner] || m_cnt == MB)) || !v[m_owner]) begin
                m_busy = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // T1: single requester, three beats ending with last
        step(4'b0001, 32'h11, 4'b0000, 0, w);
        step(4'b0001, 32'h11, 4'b0000, 0, w);
        step(4'b0001, 32'h22, 4'b0000, 0, w);
        step(4'b0001, 32'h33, 4'b0001, 0, w);
        step(4'b0000, 32'h00, 4'b0000, 0, w);
        chk("t1_count", wlog.size(), 3);
        chk("t1_w0", wlog[0], 'h11);
        chk("t1_w1", wlog[1], 'h22);
        chk("t1_w2", wlog[2], 'h33);

        // T2: all requesters streaming, bursts cut by MAX_BURST
        do_reset();
        for (int i = 0; i < 26; i++)
            step(4'b1111, 32'h44332211, 4'b0000, 0, w);
        chk("t2_g0", glog[0], 0);
        chk("t2_g1", glog[1], 1);
        chk("t2_g2", glog[2], 2);
        chk("t2_g3", glog[3], 3);
        chk("t2_g4", glog[4], 0);
        chk("t2_writes", wlog.size(), 20);

        // T3: backpressure in the middle of req1's burst
        do_reset();
        step(4'b0010, 32'h0000A000, 4'b0000, 0, w);
        step(4'b0010, 32'h0000A100, 4'b0000, 0, w);
        step(4'b0010, 32'h0000A200, 4'b0000, 0, w);
        for (int i = 0; i < 3; i++)
            step(4'b0010, 32'h0000EE00, 4'b0000, 1, w);
        step(4'b0010, 32'h0000A300, 4'b0000, 0, w);
        step(4'b0010, 32'h0000A400, 4'b0000, 0, w);
        step(4'b0000, 32'h0, 4'b0000, 0, w);
        chk("t3_grant", glog[0], 1);
        chk("t3_count", wlog.size(), 4);
        chk("t3_w2", wlog[2], 'hA3);
        chk("t3_w3", wlog[3], 'hA4);

        // T4: req2 stops early while req3 waits
        do_reset();
        step(4'b1100, 32'hD1C10000, 4'b0000, 0, w);
        step(4'b1100, 32'hD1C10000, 4'b0000, 0, w);
        step(4'b1100, 32'hD1C20000, 4'b0000, 0, w);
        step(4'b1000, 32'hD1000000, 4'b0000, 0, w);
        step(4'b1000, 32'hD1000000, 4'b1000, 0, w);
        step(4'b1000, 32'hD1000000, 4'b1000, 0, w);
        chk("t4_g0", glog[0], 2);
        chk("t4_g1", glog[1], 3);
        chk("t4_count", wlog.size(), 3);
        chk("t4_w1", wlog[1], 'hC2);

        // T5: reset in the middle of a burst, then a fresh arbitration
        do_reset();
        step(4'b0001, 32'h55, 4'b0000, 0, w);
        step(4'b0001, 32'h55, 4'b0000, 0, w);
        @(negedge clk);
        req_valid = 4'b0001;
        do_reset();
        step(4'b0101, 32'h00770055, 4'b0000, 0, w);
        step(4'b0101, 32'h00770055, 4'b0000, 0, w);
        chk("t5_grant", glog[0], 0);

        // T6: 16-deep FIFO with no reads, then four reads
        do_reset();
        occ = 0;
        for (int i = 0; i < 40; i++) begin
            step(4'b0011, {16'h0, 8'h80 + 8'(i), 8'(i)}, 4'b0000, occ >= FD, w);
            occ += int'(w);
        end
        chk("t6_fill", wlog.size(), 16);
        occ -= 4;
        for (int i = 0; i < 12; i++) begin
            step(4'b0011, {16'h0, 8'hC0 + 8'(i), 8'h40 + 8'(i)}, 4'b0000, occ >= FD, w);
            occ += int'(w);
        end
        chk("t6_total", wlog.size(), 20);

        // Randomized traffic with a draining FIFO
        do_reset();
        occ = 0;
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] v;
            logic [N-1:0] l;
            for (int k = 0; k < N; k++) begin
                v[k] = ($urandom_range(0, 3) != 0);
                l[k] = ($urandom_range(0, 3) == 0);
            end
            step(v, $urandom, l, occ >= FD, w);
            occ += int'(w);
            if (occ > 0 && $urandom_range(0, 2) == 0)
                occ--;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
